// File: rtl/pe_pkg.sv
`timescale 1ns/1ps
// Shared types and default sizes for the PE feeder: FSM state encoding and buffer depths.
package pe_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int KERNEL_SIZE_DEF = 3;
    localparam int ACT_SIZE_DEF    = 5;
    localparam int W_WORDS         = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
    localparam int A_WORDS         = ACT_SIZE_DEF * ACT_SIZE_DEF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LW,
        ST_WLW,
        ST_GAP1,
        ST_LA,
        ST_WLA,
        ST_GAP2,
        ST_START,
        ST_WC,
        ST_PUSH,
        ST_GAP3,
        ST_FIN
    } state_t;

    function automatic int sq(input int n);
        return n * n;
    endfunction

endpackage

// File: rtl/feeder_buf.sv
`timescale 1ns/1ps
// Single-write, single-read register file with a registered read port that reads zero when idle.
module feeder_buf
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = W_WORDS,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; contents must survive a reset so a later go re-streams them.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/pe_feeder.sv
`timescale 1ns/1ps
// Host-side driver for one PE: buffers kernel and activation tile, streams them, runs NUM_OUTPUTS rounds.
// Optional watchdog on the wait states is enabled with `define PE_FEEDER_TIMEOUT_EN (adds port err).
module pe_feeder
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int KERNEL_SIZE    = KERNEL_SIZE_DEF,
    parameter int ACT_SIZE       = ACT_SIZE_DEF,
    parameter int NUM_OUTPUTS    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [7:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [7:0]            res_idx,
    output logic [DATA_WIDTH-1:0] filt_out,
    output logic [DATA_WIDTH-1:0] act_out,
    output logic                  load_en_wght,
    output logic                  load_en_act,
    output logic                  start,
`ifdef PE_FEEDER_TIMEOUT_EN
    output logic                  err,
`endif
    input  logic [DATA_WIDTH-1:0] pe_out,
    input  logic                  compute_done,
    input  logic                  load_done
);

    localparam int W_N  = sq(KERNEL_SIZE);
    localparam int A_N  = sq(ACT_SIZE);
    localparam int W_AW = $clog2(W_N);
    localparam int A_AW = $clog2(A_N);

    state_t            state;
    logic [7:0]        ld_cnt;
    logic [7:0]        round;
    logic              w_rd_en;
    logic              a_rd_en;
    logic [W_AW-1:0]   w_rd_addr;
    logic [A_AW-1:0]   a_rd_addr;

    // Reads are issued one cycle ahead so the registered buffer output lines up with the strobe.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        a_rd_en   = 1'b0;
        a_rd_addr = '0;
        case (state)
            ST_IDLE: w_rd_en = go;
            ST_LW: begin
                if (ld_cnt != 8'(W_N - 1)) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = W_AW'(ld_cnt + 8'd1);
                end
            end
            ST_GAP1: a_rd_en = 1'b1;
            ST_LA: begin
                if (ld_cnt != 8'(A_N - 1)) begin
                    a_rd_en   = 1'b1;
                    a_rd_addr = A_AW'(ld_cnt + 8'd1);
                end
            end
            default: ;
        endcase
    end

    feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(W_N), .AW(W_AW)) u_wbuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && !wr_sel && (state == ST_IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (filt_out)
    );

    feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(A_N), .AW(A_AW)) u_abuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && wr_sel && (state == ST_IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (a_rd_en),
        .rd_addr (a_rd_addr),
        .rd_data (act_out)
    );

`ifdef PE_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;
    logic            wait_exit;
    logic            wd_hit;

    assign in_wait   = (state == ST_WLW) || (state == ST_WLA) || (state == ST_WC);
    assign wait_exit = (((state == ST_WLW) || (state == ST_WLA)) && load_done) ||
                       ((state == ST_WC) && compute_done);
    assign wd_hit    = in_wait && !wait_exit && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Restarts from zero on every entry into a wait state, since wait states are never adjacent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (in_wait) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ld_cnt       <= '0;
            round        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_idx      <= '0;
            load_en_wght <= 1'b0;
            load_en_act  <= 1'b0;
            start        <= 1'b0;
`ifdef PE_FEEDER_TIMEOUT_EN
            err          <= 1'b0;
`endif
        end else begin
            load_en_wght <= 1'b0;
            load_en_act  <= 1'b0;
            start        <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state        <= ST_LW;
                        busy         <= 1'b1;
                        ld_cnt       <= '0;
                        round        <= '0;
                        load_en_wght <= 1'b1;
`ifdef PE_FEEDER_TIMEOUT_EN
                        err          <= 1'b0;
`endif
                    end
                end
                ST_LW: begin
                    if (ld_cnt == 8'(W_N - 1)) begin
                        state  <= ST_WLW;
                        ld_cnt <= '0;
                    end else begin
                        ld_cnt <= ld_cnt + 8'd1;
                    end
                end
                ST_WLW: if (load_done) state <= ST_GAP1;
                ST_GAP1: begin
                    state       <= ST_LA;
                    load_en_act <= 1'b1;
                end
                ST_LA: begin
                    if (ld_cnt == 8'(A_N - 1)) begin
                        state  <= ST_WLA;
                        ld_cnt <= '0;
                    end else begin
                        ld_cnt <= ld_cnt + 8'd1;
                    end
                end
                ST_WLA: if (load_done) state <= ST_GAP2;
                ST_GAP2: begin
                    state <= ST_START;
                    start <= 1'b1;
                end
                ST_START: state <= ST_WC;
                ST_WC: begin
                    if (compute_done) begin
                        res_data  <= pe_out;
                        res_idx   <= round;
                        res_valid <= 1'b1;
                        state     <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_GAP3;
                    end
                end
                ST_GAP3: begin
                    if (round == 8'(NUM_OUTPUTS - 1)) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        round <= round + 8'd1;
                        state <= ST_START;
                        start <= 1'b1;
                    end
                end
                ST_FIN: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
`ifdef PE_FEEDER_TIMEOUT_EN
            // Later assignment overrides the wait-state branch above when the watchdog expires.
            if (wd_hit) begin
                state <= ST_FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
                err   <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
`timescale 1ns/1ps
// Self-checking bench for pe_feeder: host writes, stream checks, a behavioural PE and result checks.
module tb_pe_feeder;

    localparam int DW = 16;
    localparam int K  = 3;
    localparam int A  = 5;
    localparam int NO = 3;
    localparam int TO = 20;
    localparam int WN = K * K;
    localparam int AN = A * A;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [7:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          go = 1'b0;
    logic          res_ready = 1'b0;
    logic [DW-1:0] pe_out = '0;
    logic          compute_done = 1'b0;
    logic          load_done = 1'b0;
    logic          busy, done, res_valid, load_en_wght, load_en_act, start;
    logic [DW-1:0] res_data, filt_out, act_out;
    logic [7:0]    res_idx;
`ifdef PE_FEEDER_TIMEOUT_EN
    logic          err;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] hw [WN];
    logic [DW-1:0] ha [AN];
    logic [DW-1:0] pw [WN];
    logic [DW-1:0] pa [AN];
    bit            pe_compute_en = 1'b1;

    always #5 clk = ~clk;

    pe_feeder #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .ACT_SIZE(A), .NUM_OUTPUTS(NO), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .go           (go),
        .busy         (busy),
        .done         (done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_idx      (res_idx),
        .filt_out     (filt_out),
        .act_out      (act_out),
        .load_en_wght (load_en_wght),
        .load_en_act  (load_en_act),
        .start        (start),
`ifdef PE_FEEDER_TIMEOUT_EN
        .err          (err),
`endif
        .pe_out       (pe_out),
        .compute_done (compute_done),
        .load_done    (load_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Kernel applied to the activation window shifted right by r columns, truncated to DW bits.
    function automatic logic [DW-1:0] dot(input logic [DW-1:0] w [WN], input logic [DW-1:0] a [AN], input int r);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += 32'(w[i*K+j]) * 32'(a[i*A+j+r]);
        return s[DW-1:0];
    endfunction

    task automatic host_write(input bit sel, input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 8'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Behavioural PE: captures streamed words, answers loads and starts after random latencies.
    initial begin : pe_model
        int wi, ai, ldd, cdd, rnd;
        wi = -1; ai = -1; ldd = 0; cdd = 0; rnd = 0;
        forever begin
            @(posedge clk);
            #1;
            load_done    = 1'b0;
            compute_done = 1'b0;
            pe_out       = DW'($urandom);
            if (!reset) begin
                wi = -1; ai = -1; ldd = 0; cdd = 0; rnd = 0;
            end else begin
                if (ldd > 0) begin
                    ldd--;
                    if (ldd == 0) load_done = 1'b1;
                end
                if (cdd > 0) begin
                    cdd--;
                    if (cdd == 0) begin
                        compute_done = 1'b1;
                        pe_out       = dot(pw, pa, rnd);
                        rnd++;
                    end
                end
                if (load_en_wght) begin
                    wi  = 0;
                    rnd = 0;
                end
                if (wi >= 0) begin
                    pw[wi] = filt_out;
                    wi++;
                    if (wi == WN) begin
                        wi  = -1;
                        ldd = $urandom_range(1, 3);
                    end
                end
                if (load_en_act) ai = 0;
                if (ai >= 0) begin
                    pa[ai] = act_out;
                    ai++;
                    if (ai == AN) begin
                        ai  = -1;
                        ldd = $urandom_range(1, 3);
                    end
                end
                if (start && pe_compute_en) cdd = $urandom_range(1, 4);
            end
        end
    end

    // One full go..done run; stream checks optional, one round may be back-pressured for 10 cycles.
    task automatic run_and_collect(input bit check_stream, input int stall_round);
        int n;
        logic [DW-1:0] exp;
        go = 1'b1;
        tick();
        go = 1'b0;
        // A write while busy must be dropped.
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = ~hw[0];
        for (int i = 0; i < WN; i++) begin
            if (i == 1) wr_en = 1'b0;
            if (check_stream) begin
                check("ld_wght", load_en_wght, (i == 0) ? 1 : 0);
                check("filt_out", filt_out, hw[i]);
            end
            if (i < WN - 1) tick();
        end
        wr_en = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_while_busy", {busy, load_en_wght}, 2'b10);
        n = 0;
        while (!load_en_act && n < 100) begin tick(); n++; end
        check("ld_act_seen", load_en_act, 1);
        for (int i = 0; i < AN; i++) begin
            if (check_stream) begin
                check("ld_act", load_en_act, (i == 0) ? 1 : 0);
                check("act_out", act_out, ha[i]);
            end
            if (i < AN - 1) tick();
        end
        for (int r = 0; r < NO; r++) begin
            n = 0;
            while (!res_valid && n < 100) begin tick(); n++; end
            exp = dot(hw, ha, r);
            check("res_valid", res_valid, 1);
            check("res_idx", res_idx, r);
            check("res_data", res_data, exp);
            if (r == stall_round) begin
                repeat (10) begin
                    tick();
                    check("stall_valid", res_valid, 1);
                    check("stall_data", res_data, exp);
                    check("stall_start", start, 0);
                end
            end else begin
                repeat ($urandom_range(0, 3)) tick();
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("valid_drop", res_valid, 0);
        end
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        check("done_pulse", {done, busy}, 2'b10);
        tick();
        check("after_done", {done, busy}, 2'b00);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_filt_out", filt_out, 0);
        check("rst_act_out", act_out, 0);
        check("rst_strobes", {load_en_wght, load_en_act, start}, 3'b000);
        reset = 1'b1;
        tick();

        for (int i = 0; i < WN; i++) begin hw[i] = DW'(i + 1); host_write(1'b0, i, hw[i]); end
        for (int i = 0; i < AN; i++) begin ha[i] = DW'(100 + i); host_write(1'b1, i, ha[i]); end
        host_write(1'b0, 16, 16'hdead);
        host_write(1'b1, 32, 16'hbeef);
        host_write(1'b0, 9, 16'h0bad);
        run_and_collect(1'b1, 1);

        for (int i = 0; i < WN; i++) begin hw[i] = DW'($urandom); host_write(1'b0, i, hw[i]); end
        for (int i = 0; i < AN; i++) begin ha[i] = DW'($urandom); host_write(1'b1, i, ha[i]); end
        run_and_collect(1'b0, 2);

        // Reset during the activation load, then a re-run must stream the retained data.
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 0;
        while (!load_en_act && n < 100) begin tick(); n++; end
        check("pre_rst_ld_act", load_en_act, 1);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_strobes", {load_en_wght, load_en_act, start, done, res_valid}, 5'b0);
        check("midrst_data", {filt_out, act_out}, 32'h0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        run_and_collect(1'b1, 0);

`ifdef PE_FEEDER_TIMEOUT_EN
        pe_compute_en = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 0;
        while (!start && n < 200) begin tick(); n++; end
        check("to_start_seen", start, 1);
        repeat (TO) tick();
        check("to_no_done_yet", done, 0);
        tick();
        check("to_done", {done, busy}, 2'b10);
        check("to_err", err, 1);
        tick();
        check("to_err_sticky", err, 1);
        pe_compute_en = 1'b1;
        repeat (2) tick();
        run_and_collect(1'b1, -1);
        check("err_cleared", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Host-side driver for one PE: buffers a weight kernel and an activation tile written by the host, streams them into the PE through its `load_en_wght`/`load_en_act` load protocol, then issues `start` pulses and collects each `pe_out` on `compute_done`. It sits between the cluster controller and a single PE. Results are returned to the host over a valid/ready stream.

## Interface
- `DATA_WIDTH`, 16: word width, matches the PE.
- `KERNEL_SIZE`, 3: kernel edge; the weight buffer holds KERNEL_SIZE² words.
- `ACT_SIZE`, 5: activation tile edge; the activation buffer holds ACT_SIZE² words.
- `NUM_OUTPUTS`, 3: number of start/compute_done rounds per `go`.
- `TIMEOUT_CYCLES`, 255: watchdog limit, used only with the macro.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: host buffer write strobe.
- `wr_sel` in 1: 0 selects the weight buffer, 1 selects the activation buffer.
- `wr_addr` in 8: buffer word index.
- `wr_data` in DATA_WIDTH: host write data.
- `go` in 1: one-cycle pulse that starts a full load+compute run.
- `busy` out 1: high from `go` accepted until return to IDLE.
- `done` out 1: one-cycle pulse when a run completes.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out DATA_WIDTH: captured `pe_out`.
- `res_idx` out 8: result index, 0..NUM_OUTPUTS-1.
- `filt_out` out DATA_WIDTH: drives PE `filt_in`.
- `act_out` out DATA_WIDTH: drives PE `act_in`.
- `load_en_wght`, `load_en_act`, `start` out 1: drive the matching PE inputs.
- `pe_out` in DATA_WIDTH, `compute_done` in 1, `load_done` in 1: from the PE.

## Operation
- States are IDLE, LW, WLW, GAP1, LA, WLA, GAP2, START, WC, PUSH, GAP3, FIN.
- **IDLE**
  - Host writes are accepted only here; writes with an out-of-range `wr_addr` are dropped.
  - `go` moves to LW and raises `busy`.
- **LW**
  - Cycle 0: `load_en_wght`=1, `filt_out`=w[0].
  - Cycles 1..K²-1: `load_en_wght`=0, `filt_out`=w[n]. One word per cycle, no gaps.
  - Then go to WLW.
- **WLW**: wait for `load_done`=1, then GAP1.
- **GAP1**: one cycle with all PE strobes low, so the PE clears `load_done`.
- **LA**: same pattern as LW, using `load_en_act`, `act_out`, and ACT_SIZE² words. Then WLA.
- **WLA**: wait for `load_done`, then GAP2, then START.
- **START**: `start`=1 for exactly one cycle, then WC.
- **WC**: on `compute_done`=1, capture `res_data`<=`pe_out` and `res_idx`<=round, then go to PUSH.
- **PUSH**
  - `res_valid`=1 until `res_ready`; hold data stable while stalled.
  - On handshake go to GAP3 (one cycle with `start` low).
  - From GAP3: if round==NUM_OUTPUTS-1 go to FIN, else increment round and go to START.
- **FIN**: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `go` while `busy` is ignored. Asserting `load_done` or `compute_done` outside the wait states has no effect.
- Buffer contents are not cleared by reset. They persist across runs, so a repeated `go` re-streams the same data.

## Timing
- Reset values: all outputs 0, state IDLE, round 0.
- A reset mid-run aborts immediately; strobes drop asynchronously.
- `go` sampled at edge t gives `load_en_wght`=1 during cycle t+1.
- The last weight word is on `filt_out` at t+K². The same relative pattern applies to activations.
- PE strobes are registered outputs. `filt_out`/`act_out` are registered from the buffer read, so there is no combinational path from the PE to the PE.
- `res_valid` rises the cycle after `compute_done` is sampled.
- The minimum round is START + PE latency + WC + PUSH + GAP3.

## Configuration
- `PE_FEEDER_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WLW, WLA and WC.
  - On reaching TIMEOUT_CYCLES it sets output `err` (1 bit, sticky until reset or next `go`) and goes to FIN. `done` still pulses.
- Undefined: there is no counter and no `err` port; the wait states wait indefinitely.

## Structure
- Shared package `pe_pkg` holds the FSM state enum, the default DATA_WIDTH, and the localparams W_WORDS=K² and A_WORDS=ACT_SIZE².
- One sub-module `feeder_buf`: a parameterised single-write, single-read register file with a registered read. It is instantiated twice, once for weights and once for activations.

## Test plan
- **Weight stream**: write w[i]=i+1 for i=0..8, pulse `go`. Expect `load_en_wght` high for exactly 1 cycle and `filt_out` to sequence 1..9 on consecutive cycles.
- **Activation stream**: write a[i]=100+i for i=0..24. Expect `act_out` to sequence 100..124 after GAP1, with `load_en_act` as a single pulse.
- **Full run with PE model**: run with a behavioural PE model. Expect 3 results with `res_idx` 0,1,2 matching the model's `pe_out`, then a `done` pulse and `busy`=0.
- **Backpressure**: hold `res_ready`=0 for 10 cycles in PUSH. Expect `res_valid` and `res_data` stable, and no `start` issued.
- **Reset mid-run**: assert `reset` low during LA. Expect all outputs 0 immediately; a later `go` re-streams the retained buffer data.
- **Timeout** (macro on, TIMEOUT_CYCLES=20): never assert `compute_done`. Expect `err`=1 and a `done` pulse 20 cycles after entering WC.
